// File: rtl/storage_readout_ctrl_if.sv
// Readout bus: storage read port, stored byte count and UART TX handshake.
interface storage_readout_ctrl_if #(
   parameter int ADDR_W = 11
);
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] compmem_counter;
   logic [7:0]        rd_data;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output rd_addr, tx_data, tx_valid,
      input  rd_data, compmem_counter, tx_ready
   );

   modport slave (
      input  rd_addr, tx_data, tx_valid,
      output rd_data, compmem_counter, tx_ready
   );
endinterface

// File: rtl/storage_readout_ctrl.sv
// Capture/flush/readout sequencer for the compressed sample store.
// Optional trailing XOR checksum byte: define READOUT_CHECKSUM_EN.
module storage_readout_ctrl #(
   parameter int MEMSIZE      = 2048,
   parameter int ADDR_W       = $clog2(MEMSIZE),
   parameter int FLUSH_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  store_full,
   storage_readout_ctrl_if.master bus,
   output logic                  capture_en,
   output logic                  storage_clr,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     len_q
);

   localparam int CNT_W = $clog2(FLUSH_CYCLES);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLEAR,
      S_CAPTURE,
      S_FLUSH,
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
`ifdef READOUT_CHECKSUM_EN
      S_CSUM,
`endif
      S_FIN
   } state_e;

`ifdef READOUT_CHECKSUM_EN
   localparam state_e S_TAIL = S_CSUM;
`else
   localparam state_e S_TAIL = S_FIN;
`endif

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        txd_q, txd_d;
   logic              txv_q, txv_d;
   logic              xfer;
`ifdef READOUT_CHECKSUM_EN
   logic [7:0]        csum_q, csum_d;
`endif

   assign xfer = txv_q && bus.tx_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         addr_q  <= '0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
`ifdef READOUT_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      addr_d  = addr_q;
      txd_d   = txd_q;
      txv_d   = txv_q;
`ifdef READOUT_CHECKSUM_EN
      csum_d  = csum_q;
      if (xfer && state_q != S_CSUM) csum_d = csum_q ^ txd_q;
`endif
      // Each byte: load with valid low, then hold until accepted.
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = S_CAPTURE;
`ifdef READOUT_CHECKSUM_EN
            csum_d  = '0;
`endif
         end
         S_CAPTURE: begin
            if (stop || store_full) begin
               state_d = S_FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         S_FLUSH: begin
            if (cnt_q == '0) begin
               len_d   = bus.compmem_counter;
               addr_d  = '0;
               state_d = S_HDR_HI;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_HDR_HI: begin
            if (!txv_q) begin
               txd_d = 8'(len_q >> 8);
               txv_d = 1'b1;
            end else if (xfer) begin
               txv_d   = 1'b0;
               state_d = S_HDR_LO;
            end
         end
         S_HDR_LO: begin
            if (!txv_q) begin
               txd_d = len_q[7:0];
               txv_d = 1'b1;
            end else if (xfer) begin
               txv_d   = 1'b0;
               state_d = (len_q == '0) ? S_TAIL : S_DATA;
            end
         end
         S_DATA: begin
            if (!txv_q) begin
               txd_d = bus.rd_data;
               txv_d = 1'b1;
            end else if (xfer) begin
               txv_d = 1'b0;
               if (addr_q == len_q - ADDR_W'(1)) state_d = S_TAIL;
               else addr_d = addr_q + ADDR_W'(1);
            end
         end
`ifdef READOUT_CHECKSUM_EN
         S_CSUM: begin
            if (!txv_q) begin
               txd_d = csum_q;
               txv_d = 1'b1;
            end else if (xfer) begin
               txv_d   = 1'b0;
               state_d = S_FIN;
            end
         end
`endif
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.rd_addr  = addr_q;
   assign bus.tx_data  = txd_q;
   assign bus.tx_valid = txv_q;
   assign capture_en   = (state_q == S_CAPTURE);
   assign storage_clr  = (state_q == S_CLEAR);
   assign done         = (state_q == S_FIN);
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_storage_readout_ctrl.sv
// Randomized directed bench for storage_readout_ctrl against a frame-level model.
// Honors READOUT_CHECKSUM_EN the same way as the design.
module tb_storage_readout_ctrl;

   localparam int MEMSIZE = 2048;
   localparam int AW      = 11;
   localparam int FL      = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic stop = 1'b0;
   logic store_full = 1'b0;
   logic capture_en, storage_clr, busy, done;
   logic [AW-1:0] len_q;

   storage_readout_ctrl_if #(.ADDR_W(AW)) bus ();

   logic [7:0] mem [MEMSIZE];
   assign bus.rd_data = mem[bus.rd_addr];

   storage_readout_ctrl #(
      .MEMSIZE(MEMSIZE), .ADDR_W(AW), .FLUSH_CYCLES(FL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .store_full(store_full), .bus(bus.master),
      .capture_en(capture_en), .storage_clr(storage_clr),
      .busy(busy), .done(done), .len_q(len_q)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [7:0] rxq [$];
   logic [7:0] expq [$];
   int done_cnt = 0;
   int cyc = 0;
   int last_xfer_cyc = 0;
   int cap_cycles = 0;
   bit mon_en = 1'b0;
   bit bp = 1'b0;
   bit p1 = 1'b0, p2 = 1'b0, pv = 1'b0, pr = 1'b0;
   logic [7:0] pd = '0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      bus.tx_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
   end

   // Sample at the falling edge; a transfer happens at the following rise.
   always @(negedge clk) begin
      bit x;
      cyc++;
      if (capture_en) cap_cycles++;
      if (mon_en) begin
         if (p1) check("gap_after_xfer", 32'(bus.tx_valid), 32'd0);
         if (p2 && rxq.size() < expq.size())
            check("reload_after_gap", 32'(bus.tx_valid), 32'd1);
         if (pv && !pr) begin
            check("hold_valid", 32'(bus.tx_valid), 32'd1);
            check("hold_data", 32'(bus.tx_data), 32'(pd));
         end
         if (done) begin
            done_cnt++;
            check("done_timing", 32'(cyc), 32'(last_xfer_cyc + 1));
         end
      end
      x = mon_en && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1;
      if (x) begin
         rxq.push_back(bus.tx_data);
         last_xfer_cyc = cyc;
      end
      p2 = p1;
      p1 = x;
      pv = mon_en && bus.tx_valid === 1'b1;
      pr = bus.tx_ready;
      pd = bus.tx_data;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic build_exp(input int n);
      logic [7:0] c;
      expq.delete();
      rxq.delete();
      expq.push_back(8'(n / 256));
      expq.push_back(8'(n % 256));
      for (int i = 0; i < n; i++) expq.push_back(mem[i]);
      c = '0;
      foreach (expq[i]) c ^= expq[i];
`ifdef READOUT_CHECKSUM_EN
      expq.push_back(c);
`endif
   endtask

   task automatic run_capture(input int n, input int cap_len,
                              input bit use_full);
      bus.compmem_counter = AW'(n);
      build_exp(n);
      p1 = 1'b0;
      p2 = 1'b0;
      pv = 1'b0;
      mon_en = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("storage_clr_n1", 32'(storage_clr), 32'd1);
      check("capture_en_n1", 32'(capture_en), 32'd0);
      tick();
      check("capture_en_n2", 32'(capture_en), 32'd1);
      check("storage_clr_n2", 32'(storage_clr), 32'd0);
      tick(cap_len);
      if (use_full) store_full = 1'b1;
      else stop = 1'b1;
      tick();
      stop = 1'b0;
      check("capture_off", 32'(capture_en), 32'd0);
      cap_cycles = 0;
      tick(FL);
      check("len_latched", 32'(len_q), 32'(n));
   endtask

   task automatic wait_rx(input int n, input int maxc);
      int k = 0;
      while (rxq.size() < n && k < maxc) begin
         tick();
         k++;
      end
      check("rx_progress", 32'(rxq.size() >= n), 32'd1);
   endtask

   task automatic wait_done(input int maxc);
      int d0 = done_cnt;
      int k = 0;
      int m;
      while (done_cnt == d0 && k < maxc) begin
         tick();
         k++;
      end
      check("done_seen", 32'(done_cnt > d0), 32'd1);
      tick(3);
      check("done_once", 32'(done_cnt - d0), 32'd1);
      check("busy_end", 32'(busy), 32'd0);
      check("frame_len", 32'(rxq.size()), 32'(expq.size()));
      m = (rxq.size() < expq.size()) ? rxq.size() : expq.size();
      for (int i = 0; i < m; i++)
         check($sformatf("byte%0d", i), 32'(rxq[i]), 32'(expq[i]));
   endtask

   initial begin
      int n;
      tick(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_capture_en", 32'(capture_en), 32'd0);
      check("rst_storage_clr", 32'(storage_clr), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_len", 32'(len_q), 32'd0);
      check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
      reset = 1'b0;
      tick(2);

      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_in_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 5; i++) mem[i] = 8'(8'h11 + i);
      run_capture(5, 20, 1'b0);
      wait_done(200);
      check("basic_last_addr", 32'(bus.rd_addr), 32'd4);

      run_capture(0, 3, 1'b0);
      wait_done(200);
      check("empty_rd_addr", 32'(bus.rd_addr), 32'd0);

      run_capture(5, 20, 1'b0);
      wait_rx(4, 100);
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      check("ignored_busy", 32'(busy), 32'd1);
      check("ignored_cap", 32'(capture_en), 32'd0);
      wait_done(200);

      for (int i = 0; i < MEMSIZE; i++) mem[i] = 8'($urandom);
      n = $urandom_range(1, 40);
      bp = 1'b1;
      run_capture(n, $urandom_range(1, 30), 1'b0);
      wait_done(3000);
      bp = 1'b0;
      tick(2);

      run_capture(2045, 10, 1'b1);
      wait_done(10000);
      check("full_last_addr", 32'(bus.rd_addr), 32'd2044);
      check("full_no_capture", 32'(cap_cycles), 32'd0);
      store_full = 1'b0;
      tick(2);

      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      run_capture(10, 5, 1'b0);
      wait_rx(5, 100);
      mon_en = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_rd_addr", 32'(bus.rd_addr), 32'd0);
      check("midrst_len", 32'(len_q), 32'd0);
      tick(2);
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      run_capture(10, 5, 1'b0);
      wait_done(300);
      check("fresh_last_addr", 32'(bus.rd_addr), 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
